led_blink_sequencer: RTL and testbench
======================================

// Module: led_blink_sequencer
// PURPOSE
//  Shares one status LED among N_REQ requesters. Each requester asks for a burst of K blinks.
//  A round-robin arbiter grants one requester at a time, and an FSM plays that burst.
//  An inter-burst gap follows, then the grant is released.
//  Sits between status sources (error, link, heartbeat) and the board LED pin.
// PARAMETERS
//  N_REQ      4    number of requesters, 2..8
//  CNT_W      4    width of each per-requester blink-count field
//  CLK_IN     300  input clock frequency, Hz
//  FREQ_OUT   5    blink frequency, Hz; HALF = CLK_IN/(2*FREQ_OUT) cycles per ON or OFF phase
//  GAP_HALVES 2    gap length after a burst, in HALF-period units
// PORTS
//  i_clk      in   1            clock
//  i_reset    in   1            synchronous, active-high reset
//  i_en       in   1            global LED enable; gates o_led only
//  i_req      in   N_REQ        level request, one bit per requester
//  i_count    in   N_REQ*CNT_W  blink count; requester r uses bits [r*CNT_W +: CNT_W]
//  o_grant    out  N_REQ        one-hot grant, held for the whole burst including the gap
//  o_busy     out  1            high whenever state != IDLE
//  o_done     out  1            one-cycle pulse at burst end; o_grant is still valid that cycle
//  o_led      out  1            LED drive
// BEHAVIOUR
//  Reset (i_reset=1 at a clock edge):
//   - state=IDLE; all outputs 0; tick counter 0; RR pointer = N_REQ-1, so req0 ranks first.
//  Reset mid-burst: same result; the burst is abandoned and no o_done is issued.
//  FSM states: IDLE, ON, OFF, GAP, DONE.
//  IDLE, when any i_req bit is 1 at an edge:
//   - Arbitrate round-robin, searching from pointer+1 upward with wrap.
//   - Register o_grant; latch K = the granted i_count field; pointer <= granted index.
//   - Tick counter <= 0.
//   - Next state: ON if K != 0, else DONE.
//  Tick: counter runs 0..HALF-1 in ON, OFF and GAP; tick=1 when counter==HALF-1; counter then wraps to 0.
//  ON  -> OFF on tick.
//  OFF -> ON on tick, and remaining K decrements;
//         when the last blink completes: OFF -> GAP, or OFF -> DONE if GAP_HALVES==0.
//  GAP -> DONE after GAP_HALVES ticks.
//  DONE: lasts one cycle. o_done=1; next edge -> IDLE, o_grant <= 0.
//        A new grant can be issued no earlier than the cycle after that.
//  o_led is registered: o_led = (state==ON) & i_en. ON and OFF each last exactly HALF cycles.
//  Latency: request seen at edge E0 -> o_grant and o_led rise at E0+1.
//  Requests are level-sensitive:
//   - Dropping i_req mid-burst does not abort the burst.
//   - Changing i_count after grant has no effect.
//   - Holding i_req high re-requests after IDLE.
//  Arithmetic: the tick counter is $clog2(HALF) bits wide. The K counter is CNT_W bits and never underflows.
//  i_en=0 does not pause the sequence; it only forces o_led to 0.
// CONFIGURATION
//  LED_SEQ_FIXED_PRIO_EN
//   - Defined: fixed priority, lowest index wins; the RR pointer is removed.
//   - Undefined: round-robin as described above.
// STRUCTURE
//  Package led_pkg:
//   - seq_state_t enum {IDLE, ON, OFF, GAP, DONE}
//   - HALF-period calculation constant
//   - clog2 helper
//  Sub-module led_tick_gen: HALF-period prescaler with sync clear and enable, output tick.
//  The arbiter and FSM stay in this module.
// TESTING (CLK_IN=300, FREQ_OUT=5 -> HALF=30; GAP_HALVES=2)
//  1. req0=1, count0=3, single edge: o_led high 30 / low 30, three times.
//     Then 60-cycle gap; o_done at cycle 241 after the grant edge.
//  2. req1 and req2 both held continuously: grants alternate 0010, 0100, 0010, ...
//     With LED_SEQ_FIXED_PRIO_EN defined: 0010 always.
//  3. count=0 on req3: o_grant=1000 for 1 cycle with o_done=1; o_led never rises.
//  4. i_reset pulsed at cycle 45 of a burst: next cycle all outputs 0 with no o_done.
//     req0 is granted first afterwards.
//  5. i_en=0 for a whole 2-blink burst: o_led stays 0; o_done still occurs at cycle 181.
//  6. i_req dropped 1 cycle after grant, count=2: the full burst still plays and o_done asserts.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and constant helpers for the LED blink sequencer.
// Holds the FSM state encoding plus the half-period and width calculations.
package led_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ON   = 3'd1,
    OFF  = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } seq_state_t;

  localparam int DEF_CLK_IN   = 300;
  localparam int DEF_FREQ_OUT = 5;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return (width < 1) ? 1 : width;
  endfunction

  // Cycles spent in a single ON or OFF phase.
  function automatic int half_cycles(input int clk_in, input int freq_out);
    return clk_in / (2 * freq_out);
  endfunction

  localparam int DEF_HALF = half_cycles(DEF_CLK_IN, DEF_FREQ_OUT);

endpackage

// File: rtl/led_tick_gen.sv
// Half-period prescaler: counts 0..HALF-1 while enabled and pulses tick on the last count.
// A synchronous clear (or reset) returns the count to 0; clear wins over enable.
module led_tick_gen
  import led_pkg::*;
#(
  parameter int HALF = DEF_HALF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = clog2(HALF);

  logic [W-1:0] cnt;
  logic         at_end;

  assign at_end = (cnt == W'(HALF - 1));
  assign tick   = en & at_end;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_end ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/led_blink_sequencer.sv
// Shares one status LED among N_REQ requesters: arbitrate, play K blinks, idle a gap, release.
// Define LED_SEQ_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module led_blink_sequencer
  import led_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int CNT_W      = 4,
  parameter int CLK_IN     = DEF_CLK_IN,
  parameter int FREQ_OUT   = DEF_FREQ_OUT,
  parameter int GAP_HALVES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_en,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*CNT_W-1:0] i_count,
  output logic [N_REQ-1:0]       o_grant,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_led
);

  localparam int HALF = half_cycles(CLK_IN, FREQ_OUT);
  localparam int IW   = clog2(N_REQ);
  localparam int GW   = clog2(GAP_HALVES + 1);

  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] k_rem, k_nxt;
  logic [GW-1:0]    gap_cnt, gap_nxt;
  logic [N_REQ-1:0] grant_nxt;
  logic             tick, tick_en, tick_clr;

  logic [CNT_W-1:0] req_cnt [N_REQ];
  logic [CNT_W-1:0] win_cnt;
  logic [IW-1:0]    win_idx;
  logic [N_REQ-1:0] win_onehot;
  logic             win_vld;

  always_comb begin
    for (int r = 0; r < N_REQ; r++) begin
      req_cnt[r] = i_count[r*CNT_W +: CNT_W];
    end
  end

`ifdef LED_SEQ_FIXED_PRIO_EN
  // Descending scan so the lowest requesting index is the last writer.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (i_req[IW'(i)]) begin
        win_vld = 1'b1;
        win_idx = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] ptr, ptr_nxt;
  int            idx;

  // Scan offsets N_REQ..1 so the requester nearest after ptr is the last writer.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (i_req[IW'(idx)]) begin
        win_vld = 1'b1;
        win_idx = IW'(idx);
      end
    end
  end
`endif

  assign win_cnt    = req_cnt[win_idx];
  assign win_onehot = N_REQ'(1) << win_idx;

  led_tick_gen #(
    .HALF(HALF)
  ) u_tick (
    .clk  (i_clk),
    .reset(i_reset),
    .clr  (tick_clr),
    .en   (tick_en),
    .tick (tick)
  );

  always_comb begin
    state_nxt = state;
    k_nxt     = k_rem;
    gap_nxt   = gap_cnt;
    grant_nxt = o_grant;
    tick_en   = 1'b0;
    tick_clr  = 1'b0;
`ifndef LED_SEQ_FIXED_PRIO_EN
    ptr_nxt   = ptr;
`endif
    case (state)
      IDLE: begin
        tick_clr = 1'b1;
        if (win_vld) begin
          grant_nxt = win_onehot;
          k_nxt     = win_cnt;
          gap_nxt   = '0;
`ifndef LED_SEQ_FIXED_PRIO_EN
          ptr_nxt   = win_idx;
`endif
          state_nxt = (win_cnt != '0) ? ON : DONE;
        end
      end
      ON: begin
        tick_en = 1'b1;
        if (tick) state_nxt = OFF;
      end
      OFF: begin
        tick_en = 1'b1;
        if (tick) begin
          if (k_rem != '0) k_nxt = k_rem - CNT_W'(1);
          if (k_rem <= CNT_W'(1)) begin
            state_nxt = (GAP_HALVES == 0) ? DONE : GAP;
          end else begin
            state_nxt = ON;
          end
        end
      end
      GAP: begin
        tick_en = 1'b1;
        if (tick) begin
          if (gap_cnt == GW'(GAP_HALVES - 1)) begin
            state_nxt = DONE;
          end else begin
            gap_nxt = gap_cnt + GW'(1);
          end
        end
      end
      DONE: begin
        tick_clr  = 1'b1;
        grant_nxt = '0;
        state_nxt = IDLE;
      end
      default: begin
        tick_clr  = 1'b1;
        grant_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // o_led is registered from the next state so it lines up with the ON phase exactly.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      k_rem   <= '0;
      gap_cnt <= '0;
      o_grant <= '0;
      o_led   <= 1'b0;
`ifndef LED_SEQ_FIXED_PRIO_EN
      ptr     <= IW'(N_REQ - 1);
`endif
    end else begin
      state   <= state_nxt;
      k_rem   <= k_nxt;
      gap_cnt <= gap_nxt;
      o_grant <= grant_nxt;
      o_led   <= (state_nxt == ON) & i_en;
`ifndef LED_SEQ_FIXED_PRIO_EN
      ptr     <= ptr_nxt;
`endif
    end
  end

  assign o_busy = (state != IDLE);
  assign o_done = (state == DONE);

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Bench for led_blink_sequencer: directed scenarios plus random traffic against an offset-based model.
module tb_led_blink_sequencer;

  localparam int N_REQ      = 4;
  localparam int CNT_W      = 4;
  localparam int CLK_IN     = 300;
  localparam int FREQ_OUT   = 5;
  localparam int GAP_HALVES = 2;
  localparam int HALF       = CLK_IN / (2 * FREQ_OUT);

  logic                   clk = 1'b0;
  logic                   i_reset = 1'b1;
  logic                   i_en = 1'b1;
  logic [N_REQ-1:0]       i_req = '0;
  logic [N_REQ*CNT_W-1:0] i_count = '0;
  logic [N_REQ-1:0]       o_grant;
  logic                   o_busy, o_done, o_led;

  int checks = 0;
  int fails  = 0;

  led_blink_sequencer #(
    .N_REQ(N_REQ), .CNT_W(CNT_W), .CLK_IN(CLK_IN),
    .FREQ_OUT(FREQ_OUT), .GAP_HALVES(GAP_HALVES)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_en(i_en), .i_req(i_req),
    .i_count(i_count), .o_grant(o_grant), .o_busy(o_busy),
    .o_done(o_done), .o_led(o_led)
  );

  always #5 clk = ~clk;

  // Reference model: a burst is a cycle offset n (1 = first cycle after the grant edge)
  // running to its total length; outputs follow from plain arithmetic on n.
  bit m_active = 0;
  int m_n = 0, m_len = 0, m_k = 0, m_idx = 0, m_ptr = N_REQ - 1;
  bit m_led = 0;

  always @(posedge clk) begin
    if (i_reset) begin
      m_active = 0;
      m_ptr    = N_REQ - 1;
    end else if (m_active) begin
      if (m_n == m_len) m_active = 0;
      else m_n++;
    end else if (i_req != 0) begin
`ifdef LED_SEQ_FIXED_PRIO_EN
      for (int c = N_REQ - 1; c >= 0; c--) if (i_req[c]) m_idx = c;
`else
      for (int off = N_REQ; off >= 1; off--) if (i_req[(m_ptr + off) % N_REQ]) m_idx = (m_ptr + off) % N_REQ;
      m_ptr = m_idx;
`endif
      m_k      = (i_count >> (m_idx * CNT_W)) & ((1 << CNT_W) - 1);
      m_len    = (m_k == 0) ? 1 : 2 * HALF * m_k + GAP_HALVES * HALF + 1;
      m_n      = 1;
      m_active = 1;
    end
    m_led = m_active && m_k > 0 && m_n <= 2 * HALF * m_k && ((m_n - 1) / HALF) % 2 == 0 && i_en;
  end

  function automatic logic [6:0] exp_vec();
    logic [3:0] g;
    g = m_active ? 4'(1 << m_idx) : 4'b0000;
    return {g, m_active, m_active && (m_n == m_len), m_led};
  endfunction

  function automatic logic [6:0] obs_vec();
    return {o_grant, o_busy, o_done, o_led};
  endfunction

  task automatic do_reset();
    i_reset = 1'b1;
    i_req   = '0;
    i_en    = 1'b1;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    i_req   = 4'b1111;
    i_count = 16'h3333;
    repeat (3) @(negedge clk);
    checks++;
    if (obs_vec() !== 7'b0) begin
      fails++;
      $display("FAIL reset_outputs got=%b want=%b", obs_vec(), 7'b0);
    end
    i_reset = 1'b0;
    i_req   = '0;
    @(negedge clk);
    checks++;
    if (obs_vec() !== 7'b0) begin
      fails++;
      $display("FAIL idle_after_reset got=%b want=%b", obs_vec(), 7'b0);
    end
  endtask

  // Plays one burst on requester r; drops i_req after hold_cyc observed cycles and scrambles counts.
  task automatic run_burst(input int r, input int k, input bit en, input int hold_cyc,
                           input int max_cyc, output int done_at, output int led_hi);
    int c;
    do_reset();
    i_en    = en;
    i_count = 16'(k << (r * CNT_W));
    i_req   = 4'(1 << r);
    c = 0; done_at = -1; led_hi = 0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL burst_model r=%0d cyc=%0d got=%b want=%b", r, cyc, obs_vec(), exp_vec());
      end
      if (o_grant != 0) c++;
      if (o_done && done_at < 0) done_at = c;
      if (o_led) led_hi++;
      if (c >= hold_cyc) begin
        i_req   = '0;
        i_count = 16'($urandom);
      end
    end
  endtask

  task automatic test_single_burst();
    int done_at, led_hi;
    run_burst(0, 3, 1'b1, 0, 260, done_at, led_hi);
    checks++;
    if (done_at !== 241) begin fails++; $display("FAIL k3_done_cycle got=%0d want=241", done_at); end
    checks++;
    if (led_hi !== 90) begin fails++; $display("FAIL k3_led_cycles got=%0d want=90", led_hi); end
  endtask

  task automatic test_en_off();
    int done_at, led_hi;
    run_burst(0, 2, 1'b0, 0, 200, done_at, led_hi);
    checks++;
    if (done_at !== 181) begin fails++; $display("FAIL en0_done_cycle got=%0d want=181", done_at); end
    checks++;
    if (led_hi !== 0) begin fails++; $display("FAIL en0_led_cycles got=%0d want=0", led_hi); end
  endtask

  task automatic test_drop_req();
    int done_at, led_hi;
    run_burst(1, 2, 1'b1, 1, 200, done_at, led_hi);
    checks++;
    if (done_at !== 181) begin fails++; $display("FAIL drop_done_cycle got=%0d want=181", done_at); end
    checks++;
    if (led_hi !== 60) begin fails++; $display("FAIL drop_led_cycles got=%0d want=60", led_hi); end
  endtask

  task automatic test_zero_count();
    int gcyc, led_hi;
    do_reset();
    i_count = 16'h0000;
    i_req   = 4'b1000;
    @(negedge clk);
    i_req = '0;
    checks++;
    if ({o_grant, o_done, o_led} !== 6'b1000_1_0) begin
      fails++;
      $display("FAIL zero_count_first got=%b want=%b", {o_grant, o_done, o_led}, 6'b1000_1_0);
    end
    gcyc = 1; led_hi = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (o_grant != 0) gcyc++;
      if (o_led) led_hi++;
    end
    checks++;
    if (gcyc !== 1 || led_hi !== 0) begin
      fails++;
      $display("FAIL zero_count_len got=%0d/%0d want=1/0", gcyc, led_hi);
    end
  endtask

  task automatic test_rr_alternate();
    logic [3:0] seq [4];
    logic [3:0] prev, want;
    int ng;
    do_reset();
    i_count = 16'h0110;
    i_req   = 4'b0110;
    prev = '0; ng = 0;
    for (int cyc = 0; cyc < 700 && ng < 4; cyc++) begin
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL rr_model cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
      end
      if (o_grant != 0 && prev == 0) begin seq[ng] = o_grant; ng++; end
      prev = o_grant;
    end
    i_req = '0;
    checks++;
    if (ng !== 4) begin fails++; $display("FAIL rr_grant_count got=%0d want=4", ng); end
    for (int j = 0; j < ng; j++) begin
`ifdef LED_SEQ_FIXED_PRIO_EN
      want = 4'b0010;
`else
      want = (j % 2 == 0) ? 4'b0010 : 4'b0100;
`endif
      checks++;
      if (seq[j] !== want) begin fails++; $display("FAIL rr_grant_%0d got=%b want=%b", j, seq[j], want); end
    end
  endtask

  task automatic test_reset_mid();
    int c;
    do_reset();
    i_count = 16'h0300;
    i_req   = 4'b0100;
    c = 0;
    for (int cyc = 0; cyc < 60 && c < 45; cyc++) begin
      @(negedge clk);
      if (o_grant != 0) c++;
      i_req = '0;
    end
    i_reset = 1'b1;
    @(negedge clk);
    checks++;
    if (obs_vec() !== 7'b0) begin fails++; $display("FAIL mid_reset_outputs got=%b want=%b", obs_vec(), 7'b0); end
    i_reset = 1'b0;
    i_count = 16'h1001;
    i_req   = 4'b1001;
    @(negedge clk);
    i_req = '0;
    checks++;
    if (o_grant !== 4'b0001) begin fails++; $display("FAIL post_reset_grant got=%b want=0001", o_grant); end
    checks++;
    if (obs_vec() !== exp_vec()) begin fails++; $display("FAIL post_reset_model got=%b want=%b", obs_vec(), exp_vec()); end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL random_model cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
      end
      i_reset = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 19) == 0) i_en = ~i_en;
      if ($urandom_range(0, 3) == 0) i_req = 4'($urandom_range(0, 15));
      for (int r = 0; r < N_REQ; r++) i_count[r*CNT_W +: CNT_W] = 4'($urandom_range(0, 2));
    end
    i_reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_rr_alternate();
    test_zero_count();
    test_reset_mid();
    test_en_off();
    test_drop_req();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
